fetch_unit: RTL and testbench

// - Instruction fetch stage of the leoRISCV core; sits directly upstream of decode/sign_extend.
// - Owns the PC, issues in-order word reads to instruction memory and buffers responses in a small FIFO.
// - Hands decode a valid/ready bundle {instr, pc, format}; format is the 3-bit immediate-format code sign_extend consumes.

---
 rtl/leo_pkg.sv | 56 +++++
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : leo_pkg                                                          |
// | Desc    : Shared leoRISCV definitions: opcodes, immediate-format codes,    |
// |           fetch FSM states, fetch bundle layout and format decode.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package leo_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate-format codes consumed by sign_extend
  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_U    = 3'b011;
  localparam logic [2:0] FMT_J    = 3'b100;
  localparam logic [2:0] FMT_NONE = 3'b111;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_e;

  // One buffered fetch result: 32 + 32 + 3 = 67 bits
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  fmt;
  } fetch_entry_t;

  function automatic logic [2:0] imm_format(input logic [31:0] instr);
    logic [2:0] f;
    f = FMT_NONE;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: f = FMT_I;
      OP_STORE:                            f = FMT_S;
      OP_BRANCH:                           f = FMT_B;
      OP_LUI, OP_AUIPC:                    f = FMT_U;
      OP_JAL:                              f = FMT_J;
      default:                             f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : fetch_unit_if                                                  |
// | Desc      : Instruction-memory request/response, redirect and decode-side  |
// |             bundle signals of the fetch stage.                             |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_format;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc, out_format,
    input  out_ready
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc, out_format,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fetch_fifo                                                        |
// | Desc   : Synchronous FIFO for fetch responses. Head is read straight from  |
// |          storage registers so there is no combinational input->output.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 67
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit to tell full from empty
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign head_data = mem[rd_ptr[AW-1:0]];
  // Push on full is accepted only when a pop frees the slot the same cycle
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;

  // Pointer update; flush discards every entry and wins over push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; cleared on reset so the head reads as zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fetch_unit                                                        |
// | Desc   : leoRISCV instruction fetch. Owns the PC, issues in-order word     |
// |          reads with credit-based flow control, discards responses made    |
// |          stale by a redirect and hands {instr, pc, format} to decode.      |
// | Config : FETCH_PERF_EN adds perf_fetched / perf_stall counters.            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fetch_unit
  import leo_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall
`endif
);
  localparam int          CW              = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C         = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] RESET_PC_ALIGN  = RESET_PC & ~32'h3;

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   redirect_target;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_net;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          credit;
  logic          req_fire;
  logic          rsp_keep;
  logic          out_fire;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  assign redirect_target = bus.redirect_pc & ~32'h3;

  // Every request holds a slot either in flight or in the FIFO, so the FIFO cannot overflow
  assign credit   = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;
  assign bus.imem_req_valid = !rst && (state == FETCH_RUN) && !bus.redirect_valid && credit;
  assign bus.imem_req_addr  = pc;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

  // A response is kept only if it is not stale and no redirect kills it this cycle
  assign rsp_keep = bus.imem_rsp_valid && (drop == '0) && !bus.redirect_valid;
  assign out_fire = bus.out_valid && bus.out_ready;

  // Everything still in flight at a redirect is stale, less what arrives right now
  assign drop_net = inflight - CW'(bus.imem_rsp_valid);

  assign push_entry = '{instr: bus.imem_rsp_data, pc: rsp_pc, fmt: imm_format(bus.imem_rsp_data)};

  assign bus.out_valid  = !fifo_empty;
  assign bus.out_instr  = head_entry.instr;
  assign bus.out_pc     = head_entry.pc;
  assign bus.out_format = head_entry.fmt;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (out_fire),
    .flush     (bus.redirect_valid),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_RUN;
    else     state <= state_next;
  end

  // FSM next state: redirect decides FLUSH vs RUN; FLUSH ends when the last stale rsp lands
  always_comb begin
    state_next = state;
    if (bus.redirect_valid) begin
      state_next = (drop_net != '0) ? FETCH_FLUSH : FETCH_RUN;
    end else begin
      case (state)
        FETCH_RUN:   state_next = FETCH_RUN;
        FETCH_FLUSH: if ((drop == '0) || ((drop == CW'(1)) && bus.imem_rsp_valid))
                       state_next = FETCH_RUN;
        default:     state_next = FETCH_RUN;
      endcase
    end
  end

  // Fetch PC: redirect target, else step one word per accepted request (wraps naturally)
  always_ff @(posedge clk) begin
    if (rst)                     pc <= RESET_PC_ALIGN;
    else if (bus.redirect_valid) pc <= redirect_target;
    else if (req_fire)           pc <= pc + 32'd4;
  end

  // Address of the next non-stale response; responses return in request order
  always_ff @(posedge clk) begin
    if (rst)                     rsp_pc <= RESET_PC_ALIGN;
    else if (bus.redirect_valid) rsp_pc <= redirect_target;
    else if (rsp_keep)           rsp_pc <= rsp_pc + 32'd4;
  end

  // Outstanding request count
  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else     inflight <= inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
  end

  // Stale-response counter
  always_ff @(posedge clk) begin
    if (rst)                                     drop <= '0;
    else if (bus.redirect_valid)                 drop <= drop_net;
    else if (bus.imem_rsp_valid && drop != '0)   drop <= drop - CW'(1);
  end

  // Overflow guard on the credit scheme
  always_ff @(posedge clk) begin
    if (!rst) assert (!(rsp_keep && fifo_full && !out_fire));
  end

`ifdef FETCH_PERF_EN
  // Delivered-bundle and decode-starved cycle counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (out_fire)                          perf_fetched <= perf_fetched + 32'd1;
      if (bus.out_ready && !bus.out_valid)   perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fetch_unit                                                     |
// | Desc   : Self-checking bench for fetch_unit: request/response/redirect     |
// |          reference model plus directed literal expectations.              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc; logic [2:0] fmt;} bnd_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

`ifdef FETCH_PERF_EN
  logic [31:0] pf1, ps1, pf2, ps2;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
`ifdef FETCH_PERF_EN
    , .perf_fetched (pf1), .perf_stall (ps1)
`endif
  );

  fetch_unit #(.RESET_PC(RST_PC2), .FIFO_DEPTH(2)) u_dut2 (
    .clk (clk), .rst (rst2), .bus (bus2)
`ifdef FETCH_PERF_EN
    , .perf_fetched (pf2), .perf_stall (ps2)
`endif
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int lat    = 1;
  int epoch  = 0;
  int first_ov = -1;
  logic [31:0] mpc = 32'h0;
  req_t pending[$];
  bnd_t expq[$];
  bnd_t olog[$];
  logic [31:0] rlog[$];
  int rlog_cyc[$];
  logic [31:0] r2log[$];
  logic fire2 = 1'b0;
  logic hold2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [2:0] fmt_of(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 3'b000;
      7'h23:                      return 3'b001;
      7'h63:                      return 3'b010;
      7'h37, 7'h17:               return 3'b011;
      7'h6F:                      return 3'b100;
      default:                    return 3'b111;
    endcase
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'hFE0718E3;
      32'h8:   return 32'h000002B7;
      32'hC:   return 32'h00B50533;
      32'h10:  return 32'h0000A023;
      32'h14:  return 32'h0000006F;
      default: return {a[13:2], 20'h00093};
    endcase
  endfunction

  // Instruction memory for dut 1: in-order, fixed latency from the pending queue
  always @(posedge clk) begin
    #2;
    if (!rst && pending.size() > 0 && pending[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memword(pending[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
  end

  // Reference model and per-cycle compare for dut 1
  always @(negedge clk) begin
    logic rdr, rv, ov, stale, exp_rv;
    req_t h;
    if (rst) begin
      pending.delete();
      expq.delete();
      epoch++;
      mpc = 32'h0;
    end else begin
      rdr = bus.redirect_valid;
      rv  = bus.imem_req_valid;
      ov  = bus.out_valid;
      stale = 1'b0;
      foreach (pending[i]) if (pending[i].epoch != epoch) stale = 1'b1;
      exp_rv = !rdr && !stale && ((pending.size() + expq.size()) < 2);
      chk("req_valid", {31'b0, rv}, {31'b0, exp_rv});
      if (rv) chk("req_addr", bus.imem_req_addr, mpc);
      chk("out_valid", {31'b0, ov}, {31'b0, expq.size() > 0});
      if (ov && expq.size() > 0) begin
        chk("out_instr", bus.out_instr, expq[0].instr);
        chk("out_pc", bus.out_pc, expq[0].pc);
        chk("out_format", {29'b0, bus.out_format}, {29'b0, expq[0].fmt});
      end
      if (ov && first_ov < 0) first_ov = cyc;
      if (ov && bus.out_ready) begin
        olog.push_back(bnd_t'{bus.out_instr, bus.out_pc, bus.out_format});
        if (expq.size() > 0) void'(expq.pop_front());
      end
      if (bus.imem_rsp_valid && pending.size() > 0) begin
        h = pending.pop_front();
        if (h.epoch == epoch && !rdr)
          expq.push_back(bnd_t'{memword(h.addr), h.addr, fmt_of(memword(h.addr))});
      end
      if (rv && bus.imem_req_ready && !rdr) begin
        pending.push_back(req_t'{mpc, epoch, cyc + lat});
        rlog.push_back(bus.imem_req_addr);
        rlog_cyc.push_back(cyc);
        mpc = mpc + 32'd4;
      end
      if (rdr) begin
        expq.delete();
        epoch++;
        mpc = bus.redirect_pc & ~32'h3;
      end
    end
    cyc++;
  end

  // Latency-1 memory for dut 2; hold2 withholds responses to keep it flushing
  always @(negedge clk) begin
    fire2 = bus2.imem_req_valid && bus2.imem_req_ready && !rst2;
    if (fire2) r2log.push_back(bus2.imem_req_addr);
  end
  always @(posedge clk) begin
    #2;
    bus2.imem_rsp_valid = fire2 && !hold2 && !rst2;
    bus2.imem_rsp_data  = 32'h0000_0013;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, n0;
    bit found;
    rst = 1'b1; rst2 = 1'b1;
    bus.imem_req_ready = 1'b0; bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
    bus2.imem_req_ready = 1'b1; bus2.out_ready = 1'b1;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'h0;
    bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_format", {29'b0, bus.out_format}, 32'h0);

    // Streaming fetch, latency 1
    @(posedge clk); #1;
    rst = 1'b0; bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1; lat = 1;
    step(20);
    chk("addr0", rlog[0], 32'h0);
    chk("addr1", rlog[1], 32'h4);
    chk("addr2", rlog[2], 32'h8);
    chk("first_latency", first_ov - rlog_cyc[0], 32'd2);
    chk("olog_count", {31'b0, olog.size() >= 6}, 32'd1);
    chk("b0_pc", olog[0].pc, 32'h0);
    chk("b0_instr", olog[0].instr, 32'h00500093);
    chk("b0_fmt", {29'b0, olog[0].fmt}, 32'd0);
    chk("b1_pc", olog[1].pc, 32'h4);
    chk("b1_fmt", {29'b0, olog[1].fmt}, 32'd2);
    chk("b2_fmt", {29'b0, olog[2].fmt}, 32'd3);
    chk("b3_instr", olog[3].instr, 32'h00B50533);
    chk("b3_fmt", {29'b0, olog[3].fmt}, 32'd7);
    chk("b4_fmt", {29'b0, olog[4].fmt}, 32'd1);
    chk("b5_pc", olog[5].pc, 32'h14);
    chk("b5_fmt", {29'b0, olog[5].fmt}, 32'd4);

    // Drain, redirect with nothing in flight (low bits ignored), then back-pressure
    bus.imem_req_ready = 1'b0;
    step(6);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0202;
    step(1);
    bus.redirect_valid = 1'b0; bus.out_ready = 1'b0; bus.imem_req_ready = 1'b1;
    n0 = rlog.size();
    step(10);
    chk("bp_req_count", rlog.size() - n0, 32'd2);
    chk("bp_addr0", rlog[n0], 32'h200);
    chk("bp_addr1", rlog[n0+1], 32'h204);
    chk("bp_req_valid_low", {31'b0, bus.imem_req_valid}, 32'h0);
    k = olog.size();
    bus.out_ready = 1'b1;
    step(6);
    chk("bp_out0_pc", olog[k].pc, 32'h200);
    chk("bp_out1_pc", olog[k+1].pc, 32'h204);

    // Redirect with two requests in flight (latency 3)
    bus.imem_req_ready = 1'b0;
    step(6);
    lat = 3;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; bus.imem_req_ready = 1'b1;
    step(1);
    bus.redirect_valid = 1'b0;
    step(2);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    k = olog.size();
    step(1);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("flush_rv_a", {31'b0, bus.imem_req_valid}, 32'h0);
    @(negedge clk);
    chk("flush_rv_b", {31'b0, bus.imem_req_valid}, 32'h0);
    @(negedge clk);
    chk("flush_exit_rv", {31'b0, bus.imem_req_valid}, 32'h1);
    chk("flush_exit_addr", bus.imem_req_addr, 32'h100);
    step(12);
    chk("after_flush_pc", olog[k].pc, 32'h100);
    chk("after_flush_instr", olog[k].instr, 32'h04000093);

    // Redirect coinciding with an out transfer and a response arrival
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #3;
      if (bus.out_valid && bus.imem_rsp_valid) found = 1'b1;
    end
    chk("coincide_found", {31'b0, found}, 32'h1);
    k = olog.size();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    step(8);
    chk("coincide_next_pc", olog[k+1].pc, 32'h300);

    // Mixed ready patterns with a mid-stream redirect
    lat = 2;
    for (int i = 0; i < 60; i++) begin
      bus.out_ready      = (i % 3) != 0;
      bus.imem_req_ready = (i % 5) != 1;
      bus.redirect_valid = (i == 30);
      bus.redirect_pc    = 32'h1000;
      step(1);
    end
    bus.redirect_valid = 1'b0; bus.out_ready = 1'b1; bus.imem_req_ready = 1'b0;
    step(10);
    chk("drained_out_valid", {31'b0, bus.out_valid}, 32'h0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", pf1, olog.size());
`endif

    // Second instance: PC wrap and reset during FLUSH
    @(posedge clk); #1;
    rst2 = 1'b0;
    step(10);
    chk("wrap_count", {31'b0, r2log.size() >= 3}, 32'h1);
    chk("wrap_addr0", r2log[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", r2log[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", r2log[2], 32'h0000_0000);
    hold2 = 1'b1;
    step(6);
    bus2.redirect_valid = 1'b1; bus2.redirect_pc = 32'h500;
    step(1);
    bus2.redirect_valid = 1'b0;
    @(negedge clk);
    chk("d2_flush_rv", {31'b0, bus2.imem_req_valid}, 32'h0);
    chk("d2_flush_ov", {31'b0, bus2.out_valid}, 32'h0);
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(negedge clk);
    chk("d2_rst_rv", {31'b0, bus2.imem_req_valid}, 32'h0);
    @(posedge clk); #1;
    rst2 = 1'b0; hold2 = 1'b0;
    @(negedge clk);
    chk("d2_post_rst_ov", {31'b0, bus2.out_valid}, 32'h0);
    chk("d2_post_rst_rv", {31'b0, bus2.imem_req_valid}, 32'h1);
    chk("d2_post_rst_addr", bus2.imem_req_addr, RST_PC2);
    chk("d2_post_rst_instr", bus2.out_instr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
